// File: rtl/icache_if.sv
// icache_if: fetch <-> icache <-> memory link.
//   proc2Icache_addr        fetch byte address (from ifetch)
//   Icache2proc_data        64-bit line for the current address
//   Icache2proc_data_valid  line is a hit for this cycle's address
//   proc2Imem_command       BUS_NONE / BUS_LOAD
//   proc2Imem_addr          line address of the outstanding load, 0 otherwise
//   Imem2proc_response      nonzero = load accepted, value is its tag
//   Imem2proc_data          fill data
//   Imem2proc_tag           nonzero = fill data belongs to this tag
// slave modport is the cache; master modport is the environment driving it.
interface icache_if;
    localparam int XLEN = 32;

    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache2proc_data;
    logic            Icache2proc_data_valid;
    logic [1:0]      proc2Imem_command;
    logic [XLEN-1:0] proc2Imem_addr;
    logic [3:0]      Imem2proc_response;
    logic [63:0]     Imem2proc_data;
    logic [3:0]      Imem2proc_tag;

    modport slave (
        input  proc2Icache_addr,
        output Icache2proc_data,
        output Icache2proc_data_valid,
        output proc2Imem_command,
        output proc2Imem_addr,
        input  Imem2proc_response,
        input  Imem2proc_data,
        input  Imem2proc_tag
    );

    modport master (
        output proc2Icache_addr,
        input  Icache2proc_data,
        input  Icache2proc_data_valid,
        input  proc2Imem_command,
        input  proc2Imem_addr,
        output Imem2proc_response,
        output Imem2proc_data,
        output Imem2proc_tag
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 8-byte lines.
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; clears valid bits and the miss FSM
//   bus    icache_if.slave (fetch request/response and memory load bus)
// A miss issues one tagged BUS_LOAD; the fill is written at the edge the
// matching tag arrives and the address hits from the following cycle.
module icache #(
    parameter  int NUM_LINES = 32,
    localparam int IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic     clock,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int XLEN = 32;
    localparam int TAG_BITS = XLEN - 3 - IDX_BITS;
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    logic [63:0]         data_mem [NUM_LINES];
    logic [TAG_BITS-1:0] tag_mem  [NUM_LINES];

    state_t              state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
    logic [XLEN-4:0]     fill_line_q, fill_line_d;
    logic [3:0]          pend_tag_q, pend_tag_d;

    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;
    logic                hit;
    logic                fill_we;
    logic                unused_offset;

    assign unused_offset = &{1'b0, bus.proc2Icache_addr[2:0]};

    assign req_idx  = bus.proc2Icache_addr[3 +: IDX_BITS];
    assign req_tag  = bus.proc2Icache_addr[XLEN-1 : 3+IDX_BITS];
    assign fill_idx = fill_line_q[IDX_BITS-1:0];
    assign fill_tag = fill_line_q[XLEN-4 : IDX_BITS];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // While a miss is outstanding the fetch is held off even if a redirected
    // address happens to be resident; it is re-evaluated once back in IDLE.
    assign bus.Icache2proc_data_valid = hit && (state_q == IDLE);
    assign bus.Icache2proc_data       = bus.Icache2proc_data_valid ? data_mem[req_idx] : 64'h0;
    assign bus.proc2Imem_command      = cmd_q;
    assign bus.proc2Imem_addr         = mem_addr_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        cmd_d       = cmd_q;
        mem_addr_d  = mem_addr_q;
        fill_line_d = fill_line_q;
        pend_tag_d  = pend_tag_q;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d     = REQ;
                    cmd_d       = BUS_LOAD;
                    mem_addr_d  = {bus.proc2Icache_addr[XLEN-1:3], 3'b000};
                    fill_line_d = bus.proc2Icache_addr[XLEN-1:3];
                end
            end
            REQ: begin
                if (bus.Imem2proc_response != 4'h0) begin
                    state_d    = WAIT;
                    pend_tag_d = bus.Imem2proc_response;
                    cmd_d      = BUS_NONE;
                    mem_addr_d = '0;
                end
            end
            WAIT: begin
                if ((bus.Imem2proc_tag != 4'h0) && (bus.Imem2proc_tag == pend_tag_q)) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    pend_tag_d        = 4'h0;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                cmd_d      = BUS_NONE;
                mem_addr_d = '0;
                pend_tag_d = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            cmd_q       <= BUS_NONE;
            mem_addr_q  <= '0;
            fill_line_q <= '0;
            pend_tag_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cmd_q       <= cmd_d;
            mem_addr_q  <= mem_addr_d;
            fill_line_q <= fill_line_d;
            pend_tag_q  <= pend_tag_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_mem[fill_idx] <= bus.Imem2proc_data;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
module tb_icache;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0013;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'hCAFE_F00D_0000_0200;
    localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;

    icache_if bus();
    icache #(.NUM_LINES(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a);
        bus.proc2Icache_addr = a;
        #1;
    endtask

    initial begin
        bus.proc2Icache_addr   = 32'h0;
        bus.Imem2proc_response = 4'h0;
        bus.Imem2proc_data     = 64'h0;
        bus.Imem2proc_tag      = 4'h0;
        #12;
        check("rst_cmd", {62'h0, bus.proc2Imem_command}, 64'h0);
        check("rst_maddr", {32'h0, bus.proc2Imem_addr}, 64'h0);
        check("rst_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        check("rst_data", bus.Icache2proc_data, 64'h0);
        bus.proc2Icache_addr = 32'h0000_0100;
        @(negedge clock);
        reset = 1'b0;

        // 1: cold miss
        tick();
        check("t1_req_cmd", {62'h0, bus.proc2Imem_command}, 64'h1);
        check("t1_req_addr", {32'h0, bus.proc2Imem_addr}, 64'h100);
        check("t1_dv_miss", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        bus.Imem2proc_response = 4'd3;
        tick();
        bus.Imem2proc_response = 4'd0;
        check("t1_wait_cmd", {62'h0, bus.proc2Imem_command}, 64'h0);
        check("t1_wait_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        bus.Imem2proc_tag  = 4'd3;
        bus.Imem2proc_data = D1;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t1_fill_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h1);
        check("t1_fill_data", bus.Icache2proc_data, D1);

        // 2: hit on another offset of the same line
        set_addr(32'h0000_0104);
        check("t2_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h1);
        check("t2_data", bus.Icache2proc_data, D1);
        tick();
        check("t2_cmd", {62'h0, bus.proc2Imem_command}, 64'h0);

        // 3: back-pressure, foreign tag ignored (0x110 -> index 2)
        set_addr(32'h0000_0110);
        check("t3_dv_miss", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold_cmd%0d", i), {62'h0, bus.proc2Imem_command}, 64'h1);
            check($sformatf("t3_hold_addr%0d", i), {32'h0, bus.proc2Imem_addr}, 64'h110);
            tick();
        end
        bus.Imem2proc_response = 4'd7;
        tick();
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag  = 4'd2;
        bus.Imem2proc_data = D4;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t3_foreign_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        tick();
        check("t3_still_wait_cmd", {62'h0, bus.proc2Imem_command}, 64'h0);
        check("t3_still_wait_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        bus.Imem2proc_tag  = 4'd7;
        bus.Imem2proc_data = D2;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t3_fill_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h1);
        check("t3_fill_data", bus.Icache2proc_data, D2);

        // 4: conflict at index 0 (0x200 evicts 0x100), then refill 0x100
        set_addr(32'h0000_0200);
        check("t4_dv_miss", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        tick();
        check("t4_req_addr", {32'h0, bus.proc2Imem_addr}, 64'h200);
        bus.Imem2proc_response = 4'd1;
        tick();
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag  = 4'd1;
        bus.Imem2proc_data = D3;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t4_fill_data", bus.Icache2proc_data, D3);
        set_addr(32'h0000_0100);
        check("t4_evicted_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        set_addr(32'h0000_0110);
        check("t4_idx2_kept", bus.Icache2proc_data, D2);
        set_addr(32'h0000_0100);
        tick();
        check("t4_refill_addr", {32'h0, bus.proc2Imem_addr}, 64'h100);
        bus.Imem2proc_response = 4'd4;
        tick();
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag  = 4'd4;
        bus.Imem2proc_data = D1;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t4_refill_data", bus.Icache2proc_data, D1);

        // 5: redirect to a resident line while waiting on 0x308 (index 1)
        set_addr(32'h0000_0308);
        tick();
        check("t5_req_addr", {32'h0, bus.proc2Imem_addr}, 64'h308);
        bus.Imem2proc_response = 4'd6;
        tick();
        bus.Imem2proc_response = 4'd0;
        set_addr(32'h0000_0100);
        check("t5_redirect_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        tick();
        check("t5_redirect_dv2", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        bus.Imem2proc_tag  = 4'd6;
        bus.Imem2proc_data = D4;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t5_after_fill_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h1);
        check("t5_after_fill_data", bus.Icache2proc_data, D1);
        set_addr(32'h0000_0308);
        check("t5_filled_line", bus.Icache2proc_data, D4);

        // 6: async reset while waiting on tag 5 (0x118 -> index 3)
        set_addr(32'h0000_0118);
        tick();
        bus.Imem2proc_response = 4'd5;
        tick();
        bus.Imem2proc_response = 4'd0;
        set_addr(32'h0000_0100);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_cmd", {62'h0, bus.proc2Imem_command}, 64'h0);
        check("t6_rst_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        check("t6_rst_data", bus.Icache2proc_data, 64'h0);
        tick();
        reset = 1'b0;
        set_addr(32'h0000_0118);
        bus.Imem2proc_tag  = 4'd5;
        bus.Imem2proc_data = D2;
        tick();
        bus.Imem2proc_tag = 4'd0;
        check("t6_late_tag_dv", {63'h0, bus.Icache2proc_data_valid}, 64'h0);
        check("t6_late_tag_cmd", {62'h0, bus.proc2Imem_command}, 64'h1);
        tick();
        check("t6_late_tag_dv2", {63'h0, bus.Icache2proc_data_valid}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
